tone_detector: RTL and testbench

// Measures the half-period of an incoming square wave and decodes it back to the
// 3-bit note code (0=Do .. 7=Do2) that the tone generator plays for SW.

---
 rtl/tone_detector.sv | 137 +++++++++++++
 tb/tb_tone_detector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// tone_detector: measures a square wave's half-period and decodes it into a locked 3-bit note code
// Ports:
//   inclk       system clock, the only clock
//   rst         asynchronous active-high reset
//   tone_in     square wave, asynchronous to inclk
//   half_period last published half-period measurement, in inclk cycles
//   meas_strobe one-cycle pulse when half_period updates
//   note        decoded note code (0=Do .. 7=Do2), holds its last locked value
//   note_valid  high while locked on a note
// NOM_SHIFT right-shifts the nominal table (0 = real audio pitches).
module tone_detector #(
    parameter int CNT_W      = 32,
    parameter int TOL        = 64,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 131072,
    parameter int NOM_SHIFT  = 0
) (
    input  logic             inclk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_strobe,
    output logic [2:0]       note,
    output logic             note_valid
);
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [127:0] NOM_TBL = {16'h5D5D, 16'h62F1, 16'h6EF9, 16'h7CB8,
                                        16'h8BE9, 16'h9430, 16'hA65D, 16'hBAB9};
    localparam logic [CNT_W-1:0] T_MAX   = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q, hist_q;
    logic             tone_edge, timed_out, hit;
    logic [CNT_W-1:0] cnt_q, cnt_d, nom, diff;
    logic [MC_W-1:0]  match_cnt_q, mc_inc;
    logic [2:0]       cand_q, hit_idx;

    // Both polarities count; the sync chain delays every edge equally, so intervals stay exact.
    assign tone_edge = sync2_q ^ hist_q;
    assign timed_out = cnt_q == T_MAX;
    assign cnt_d     = tone_edge ? CNT_W'(1) : timed_out ? cnt_q : cnt_q + CNT_W'(1);
    assign mc_inc    = match_cnt_q == MC_LOCK ? match_cnt_q : match_cnt_q + MC_W'(1);

    // Windows are disjoint, so at most one note can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        nom     = '0;
        diff    = '0;
        for (int k = 0; k < 8; k++) begin
            nom  = CNT_W'(NOM_TBL[k*16 +: 16] >> NOM_SHIFT);
            diff = cnt_q >= nom ? cnt_q - nom : nom - cnt_q;
            if (diff <= CNT_W'(TOL)) begin
                hit     = 1'b1;
                hit_idx = 3'(k);
            end
        end
    end

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            match_cnt_q <= '0;
            cand_q      <= 3'd0;
            half_period <= '0;
            meas_strobe <= 1'b0;
            note        <= 3'd0;
            note_valid  <= 1'b0;
        end else begin
            meas_strobe <= 1'b0;
            // SEARCH only takes the reference edge; there is no interval to publish yet.
            if (tone_edge && state_q != SEARCH) begin
                half_period <= cnt_q;
                meas_strobe <= 1'b1;
            end
            case (state_q)
                SEARCH: begin
                    if (tone_edge)
                        state_q <= MEASURE;
                end
                MEASURE: begin
                    if (tone_edge) begin
                        if (hit && hit_idx == cand_q) begin
                            match_cnt_q <= mc_inc;
                            if (mc_inc == MC_LOCK) begin
                                note       <= cand_q;
                                note_valid <= 1'b1;
                                state_q    <= LOCKED;
                            end
                        end else if (hit) begin
                            cand_q      <= hit_idx;
                            match_cnt_q <= MC_W'(1);
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end else if (timed_out) begin
                        state_q     <= SEARCH;
                        match_cnt_q <= '0;
                    end
                end
                LOCKED: begin
                    if (tone_edge) begin
                        // The mismatching interval seeds the next candidacy.
                        if (!(hit && hit_idx == note)) begin
                            note_valid  <= 1'b0;
                            state_q     <= MEASURE;
                            cand_q      <= hit_idx;
                            match_cnt_q <= hit ? MC_W'(1) : '0;
                        end
                    end else if (timed_out) begin
                        note_valid  <= 1'b0;
                        state_q     <= SEARCH;
                        match_cnt_q <= '0;
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: directed checks of tone_detector with a scaled nominal table
// Nominals >> 6: 0:746 1:665 2:592 3:559 4:498 5:443 6:395 7:373; TOL=8, TIMEOUT=2000.
module tb_tone_detector;
    localparam int TOUT = 2000;

    logic        inclk = 1'b0;
    logic        rst = 1'b1;
    logic        tone_in = 1'b0;
    logic [31:0] half_period;
    logic        meas_strobe;
    logic [2:0]  note;
    logic        note_valid;

    int checks = 0, errors = 0, strobes = 0, since = 0, s0 = 0;
    logic       prev_st = 1'b0, prev_valid = 1'b0;
    logic [2:0] prev_note = 3'd0;

    tone_detector #(
        .CNT_W(32), .TOL(8), .LOCK_COUNT(4), .TIMEOUT(TOUT), .NOM_SHIFT(6)
    ) dut (
        .inclk(inclk), .rst(rst), .tone_in(tone_in), .half_period(half_period),
        .meas_strobe(meas_strobe), .note(note), .note_valid(note_valid)
    );

    always #5 inclk = ~inclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge inclk);
        since += n;
    endtask

    task automatic flip();
        tone_in = ~tone_in;
        since = 0;
    endtask

    // k edges, each n cycles after the previous one
    task automatic gap(input int n, input int k);
        repeat (k) begin
            tick(n - since);
            flip();
        end
    endtask

    always @(negedge inclk) begin
        if (!rst) begin
            if (meas_strobe) begin
                strobes++;
                check("strobe_gap", 32'(prev_st), 0);
            end
            if (note != prev_note)
                check("note_on_rise", {30'd0, prev_valid, note_valid}, 1);
        end
        prev_st = meas_strobe;
        prev_valid = note_valid;
        prev_note = note;
    end

    initial begin
        repeat (4) begin
            tick(7);
            flip();
        end
        tick(2);
        check("rst_half", half_period, 0);
        check("rst_strobe", 32'(meas_strobe), 0);
        check("rst_note", 32'(note), 0);
        check("rst_valid", 32'(note_valid), 0);
        rst = 1'b0;
        tick(3);
        s0 = strobes;
        flip();
        tick(6);
        check("first_edge_strobes", strobes - s0, 0);
        check("first_edge_valid", 32'(note_valid), 0);

        gap(498, 3); tick(4);
        check("fa3_valid", 32'(note_valid), 0);
        check("fa3_strobes", strobes - s0, 3);
        check("fa3_half", half_period, 498);
        gap(498, 1); tick(4);
        check("fa4_valid", 32'(note_valid), 1);
        check("fa4_note", 32'(note), 4);
        check("fa4_strobes", strobes - s0, 4);

        gap(600, 1); tick(4);
        check("mi_hi1_valid", 32'(note_valid), 0);
        check("mi_hi1_note", 32'(note), 4);
        check("mi_hi1_half", half_period, 600);
        gap(600, 3); tick(4);
        check("mi_hi4_valid", 32'(note_valid), 1);
        check("mi_hi4_note", 32'(note), 2);
        s0 = strobes;
        gap(601, 5); tick(4);
        check("mi_out_valid", 32'(note_valid), 0);
        check("mi_out_note", 32'(note), 2);
        check("mi_out_strobes", strobes - s0, 5);
        check("mi_out_half", half_period, 601);
        gap(584, 4); tick(4);
        check("mi_lo_valid", 32'(note_valid), 1);
        check("mi_lo_half", half_period, 584);
        gap(583, 4); tick(4);
        check("mi_lo_out_valid", 32'(note_valid), 0);
        check("mi_lo_out_note", 32'(note), 2);

        gap(395, 4); tick(4);
        check("so_valid", 32'(note_valid), 1);
        check("so_note", 32'(note), 6);
        gap(746, 1); tick(4);
        check("do1_valid", 32'(note_valid), 0);
        check("do1_note", 32'(note), 6);
        gap(746, 2); tick(4);
        check("do3_valid", 32'(note_valid), 0);
        gap(746, 1); tick(4);
        check("do4_valid", 32'(note_valid), 1);
        check("do4_note", 32'(note), 0);
        check("do4_half", half_period, 746);

        tick(TOUT + 2 - since);
        check("to_before_valid", 32'(note_valid), 1);
        tick(1);
        check("to_after_valid", 32'(note_valid), 0);
        check("to_note_hold", 32'(note), 0);
        check("to_half_hold", half_period, 746);
        s0 = strobes;
        flip();
        tick(6);
        check("to_next_edge_strobes", strobes - s0, 0);

        gap(746, 4); tick(4);
        check("relock_do_valid", 32'(note_valid), 1);
        s0 = strobes;
        gap(TOUT, 1); tick(4);
        check("sat_half", half_period, TOUT);
        check("sat_valid", 32'(note_valid), 0);
        check("sat_strobes", strobes - s0, 1);
        gap(746, 1); tick(4);
        check("post_sat_strobes", strobes - s0, 2);
        check("post_sat_half", half_period, 746);

        gap(498, 4); tick(4);
        check("pre_rst_valid", 32'(note_valid), 1);
        #3;
        rst = 1'b1;
        tone_in = 1'b0;
        #1;
        check("async_valid", 32'(note_valid), 0);
        check("async_note", 32'(note), 0);
        check("async_half", half_period, 0);
        tick(3);
        rst = 1'b0;
        tick(3);
        s0 = strobes;
        flip();
        gap(498, 3); tick(4);
        check("rl3_valid", 32'(note_valid), 0);
        check("rl3_strobes", strobes - s0, 3);
        gap(498, 1); tick(4);
        check("rl4_valid", 32'(note_valid), 1);
        check("rl4_note", 32'(note), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
